// File: rtl/sad_block_search_pkg.sv
// Shared definitions for the SAD block-search engine: FSM encoding and width helpers.
// No timing of its own.
// No flow control of its own.
package sad_block_search_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // Ceiling log2; returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Width of one word's summed |a-b| across all lanes.
   function automatic int word_sad_w(input int pix_w, input int lanes);
      return pix_w + clog2(lanes);
   endfunction

endpackage

// File: rtl/sad_absdiff_lanes.sv
// Per-lane absolute difference of two packed pixel words, summed into one word SAD.
// Purely combinational, zero cycles.
// No flow control; the caller decides when the result is registered.
module sad_absdiff_lanes
   import sad_block_search_pkg::*;
#(
   parameter int LANES = 4,
   parameter int PIX_W = 8,
   localparam int SUM_W = word_sad_w(PIX_W, LANES)
) (
   input  logic [LANES*PIX_W-1:0] a,
   input  logic [LANES*PIX_W-1:0] b,
   output logic [SUM_W-1:0]       word_sad
);

   logic signed [PIX_W:0] diff [LANES];
   logic signed [PIX_W:0] mag  [LANES];

   // Zero-extended signed difference per lane, negated when negative.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign diff[i] = signed'({1'b0, a[i*PIX_W +: PIX_W]}) - signed'({1'b0, b[i*PIX_W +: PIX_W]});
      assign mag[i]  = diff[i][PIX_W] ? -diff[i] : diff[i];
   end

   // Sum all lane magnitudes; the result width covers LANES * (2^PIX_W - 1).
   always_comb begin
      word_sad = '0;
      for (int i = 0; i < LANES; i++) begin
         word_sad = word_sad + SUM_W'(unsigned'(mag[i]));
      end
   end

endmodule

// File: rtl/sad_block_search.sv
// Block-match SAD search: streams candidate blocks, reports each candidate SAD and the running minimum.
// Last beat at edge E -> sad_valid at E+2 -> best update (and done on the final candidate) at E+3.
// in_ready is high only in RUN; in_valid bubbles are absorbed without affecting results.
module sad_block_search
   import sad_block_search_pkg::*;
#(
   parameter int LANES       = 4,
   parameter int PIX_W       = 8,
   parameter int BLOCK_WORDS = 16,
   parameter int NUM_CAND    = 64,
   parameter int OUT_W       = 32,
   parameter int IDX_W       = 16
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   start,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*PIX_W-1:0] word_a,
   input  logic [LANES*PIX_W-1:0] word_b,
   output logic                   sad_valid,
   output logic [OUT_W-1:0]       cand_sad,
   output logic [IDX_W-1:0]       cand_idx,
   output logic [OUT_W-1:0]       best_sad,
   output logic [IDX_W-1:0]       best_idx,
   output logic                   busy,
   output logic                   done
);

   localparam int WSAD_W = word_sad_w(PIX_W, LANES);
   localparam int WC_W   = (clog2(BLOCK_WORDS) < 1) ? 1 : clog2(BLOCK_WORDS);
   localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(BLOCK_WORDS - 1);
   localparam logic [IDX_W-1:0] LAST_CAND = IDX_W'(NUM_CAND - 1);

   logic [1:0]       state;
   logic [WC_W-1:0]  word_cnt;
   logic [IDX_W-1:0] cand_cnt;
   logic             accept;
   logic             start_search;
   logic             is_first;
   logic             is_last;
   logic             is_final;

   // Input capture stage (registered on the accept edge)
   logic                   s0_vld;
   logic [LANES*PIX_W-1:0] s0_a;
   logic [LANES*PIX_W-1:0] s0_b;
   logic                   s0_first;
   logic                   s0_last;
   logic                   s0_final;
   logic [IDX_W-1:0]       s0_idx;

   // Word-SAD stage (accept edge + 1)
   logic [WSAD_W-1:0]      lane_sad;
   logic                   s1_vld;
   logic [WSAD_W-1:0]      s1_sad;
   logic                   s1_first;
   logic                   s1_last;
   logic                   s1_final;
   logic [IDX_W-1:0]       s1_idx;

   // Accumulate stage (accept edge + 2)
   logic [OUT_W-1:0]       acc;
   logic [OUT_W:0]         acc_sum;
   logic [OUT_W-1:0]       acc_next;
   logic                   sad_final;

   assign in_ready     = (state == ST_RUN);
   assign busy         = (state != ST_IDLE);
   assign accept       = in_valid && in_ready;
   assign start_search = (state == ST_IDLE) && start;
   assign is_first     = (word_cnt == '0);
   assign is_last      = (word_cnt == LAST_WORD);
   assign is_final     = is_last && (cand_cnt == LAST_CAND);

   // Search FSM with word/candidate counters; DRAIN ends on the final compare.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= ST_IDLE;
         word_cnt <= '0;
         cand_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_RUN;
                  word_cnt <= '0;
                  cand_cnt <= '0;
               end
            end
            ST_RUN: begin
               if (accept) begin
                  if (is_last) begin
                     word_cnt <= '0;
                     if (cand_cnt == LAST_CAND) begin
                        state <= ST_DRAIN;
                     end else begin
                        cand_cnt <= cand_cnt + 1'b1;
                     end
                  end else begin
                     word_cnt <= word_cnt + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (sad_valid && sad_final) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Capture accepted pixels together with their position in the search.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         s0_vld   <= 1'b0;
         s0_a     <= '0;
         s0_b     <= '0;
         s0_first <= 1'b0;
         s0_last  <= 1'b0;
         s0_final <= 1'b0;
         s0_idx   <= '0;
      end else begin
         s0_vld <= accept;
         if (accept) begin
            s0_a     <= word_a;
            s0_b     <= word_b;
            s0_first <= is_first;
            s0_last  <= is_last;
            s0_final <= is_final;
            s0_idx   <= cand_cnt;
         end
      end
   end

   sad_absdiff_lanes #(
      .LANES (LANES),
      .PIX_W (PIX_W)
   ) u_absdiff (
      .a        (s0_a),
      .b        (s0_b),
      .word_sad (lane_sad)
   );

   // Register the per-word SAD.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_vld   <= 1'b0;
         s1_sad   <= '0;
         s1_first <= 1'b0;
         s1_last  <= 1'b0;
         s1_final <= 1'b0;
         s1_idx   <= '0;
      end else begin
         s1_vld <= s0_vld;
         if (s0_vld) begin
            s1_sad   <= lane_sad;
            s1_first <= s0_first;
            s1_last  <= s0_last;
            s1_final <= s0_final;
            s1_idx   <= s0_idx;
         end
      end
   end

   // First word of a candidate reloads; later words add and clamp at all ones.
   always_comb begin
      acc_sum  = {1'b0, acc} + (OUT_W + 1)'(s1_sad);
      acc_next = acc_sum[OUT_W] ? {OUT_W{1'b1}} : acc_sum[OUT_W-1:0];
      if (s1_first) begin
         acc_next = OUT_W'(s1_sad);
      end
   end

   // Accumulate and publish the finished candidate on its last word.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         acc       <= '0;
         sad_valid <= 1'b0;
         sad_final <= 1'b0;
         cand_sad  <= '0;
         cand_idx  <= '0;
      end else begin
         sad_valid <= s1_vld && s1_last;
         sad_final <= s1_vld && s1_final;
         if (start_search) begin
            acc <= '0;
         end else if (s1_vld) begin
            acc <= acc_next;
            if (s1_last) begin
               cand_sad <= acc_next;
               cand_idx <= s1_idx;
            end
         end
      end
   end

   // Strict-less compare keeps the earliest index on ties; done marks the final compare.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         best_sad <= '1;
         best_idx <= '0;
         done     <= 1'b0;
      end else begin
         done <= sad_valid && sad_final;
         if (start_search) begin
            best_sad <= '1;
            best_idx <= '0;
         end else if (sad_valid && (cand_sad < best_sad)) begin
            best_sad <= cand_sad;
            best_idx <= cand_idx;
         end
      end
   end

endmodule

// File: doc/sad_block_search.md
Name: sad_block_search

Overview:
- Sequential, parametrised SAD engine for block-match motion search.
- Streams packed pixel words for NUM_CAND candidate blocks, each BLOCK_WORDS long.
- Accumulates the sum of absolute differences per candidate and tracks the minimum SAD and its candidate index.
- Sits beside the datapath as a memory-fed accelerator; the core starts it and polls or waits for done.

Parameters:
LANES, 4, pixels per input word
PIX_W, 8, bits per pixel (unsigned)
BLOCK_WORDS, 16, input words per candidate block (>=1)
NUM_CAND, 64, candidates per search (>=1)
OUT_W, 32, SAD accumulator/result width
IDX_W, 16, candidate index width (2^IDX_W >= NUM_CAND)

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a search (honoured only in IDLE)
in_valid  in  1  word_a/word_b valid
in_ready  out  1  block accepts a beat (high only in RUN)
word_a  in  LANES*PIX_W  window pixels, lane i = bits [i*PIX_W +: PIX_W]
word_b  in  LANES*PIX_W  template pixels, same packing
sad_valid  out  1  one-cycle pulse: cand_sad/cand_idx hold a finished candidate
cand_sad  out  OUT_W  SAD of finished candidate
cand_idx  out  IDX_W  index of finished candidate
best_sad  out  OUT_W  running minimum SAD
best_idx  out  IDX_W  index of best_sad
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse when search complete

Behaviour:
- Reset values:
  - in_ready, sad_valid, busy, done = 0.
  - cand_sad, cand_idx, best_idx = 0.
  - best_sad = all ones.
  - State = IDLE; word and candidate counters = 0; accumulator and pipeline valids cleared.
- Reset mid-operation aborts immediately. No sad_valid or done is produced for the aborted search.
- Beat accepted on an edge where in_valid && in_ready.
- States:
  - IDLE: start -> RUN. On that edge: counters = 0, accumulator = 0, best_sad = all ones, best_idx = 0.
  - RUN: in_ready = 1. On an accepted beat with word_cnt == BLOCK_WORDS-1 and cand_cnt == NUM_CAND-1 -> DRAIN; in_ready drops the next cycle.
  - DRAIN: waits for the pipeline to empty, i.e. the final best update. Asserts done for one cycle together with the final best_sad/best_idx values, then -> IDLE.
  - start in RUN or DRAIN is ignored.
- Counter wrap:
  - word_cnt wraps to 0 after BLOCK_WORDS-1; cand_cnt then increments.
  - No bubble between candidates: the first beat of candidate k+1 may be accepted on the cycle after the last beat of k.
- Pipeline:
  - Stage 1 (accept edge +1): register per-lane |a_i - b_i|. Compute as a (PIX_W+1)-bit signed difference of zero-extended operands; if negative, negate. Sum lanes into a word SAD of PIX_W+clog2(LANES) bits.
  - Stage 2 (accept edge +2): accumulator += word SAD, saturating at 2^OUT_W-1. If the beat is the first word of a candidate, the accumulator loads the word SAD rather than adding.
  - When the stage-2 beat is the last word, cand_sad/cand_idx are loaded and sad_valid pulses on that same edge.
  - Compare (edge after sad_valid): if cand_sad < best_sad (strict), update best_sad/best_idx. Ties keep the earlier index.
- Latency: last beat of candidate k accepted at edge E -> sad_valid at E+2 -> best updated at E+3.
- For the final candidate, done is asserted at E+3.
- in_valid gaps (bubbles) are legal anywhere and do not change results.
- word_a/word_b are ignored when not accepted.
- cand_sad/cand_idx/best_* hold their values between updates and after done, until the next start.

Decomposition:
- Shared package: the state encoding (IDLE/RUN/DRAIN), a clog2 helper, and the derived width constant for the word-SAD sum. Carry no numeric defaults in the package.
- Sub-module sad_absdiff_lanes: combinational LANES-way |a-b| plus adder tree, parametrised by LANES and PIX_W. The top level owns all registers, counters, the FSM and compare logic.

Test Plan:
- Reset: assert Reset 3 cycles with random inputs -> in_ready=0, busy=0, done=0, best_sad=0xFFFFFFFF, best_idx=0, sad_valid never pulses.
- Single candidate (BLOCK_WORDS=2, NUM_CAND=1): start, then two beats A=0x00FF10FF, B=0xFF000A00 (771 each) -> sad_valid with cand_sad=1542, cand_idx=0; done 3 cycles after the second beat; best_sad=1542, best_idx=0.
- Minimum and tie (BLOCK_WORDS=1, NUM_CAND=3): candidate SADs 100, 40, 40 back to back -> three sad_valid pulses (100/0, 40/1, 40/2); final best_sad=40, best_idx=1.
- Backpressure/bubbles: repeat the tie test with in_valid low for 2 cycles between every beat, and start pulsed again mid-RUN -> identical cand/best results; extra start ignored; done pulses once.
- Saturation (OUT_W=12, BLOCK_WORDS=5, NUM_CAND=1): five beats A=0xFFFFFFFF, B=0 (1020 each) -> cand_sad=4095, not 5100 mod 4096.
- Reset mid-RUN: after 3 beats of a NUM_CAND=3 search, assert Reset 1 cycle, then start a new single-candidate search -> no stale sad_valid; results match a fresh run.
